program_loader: RTL and testbench

// Instruction-memory stage feeding the CPU fetch port (InsAddr -> Instruction).

---
 rtl/program_loader_if.sv | 19 +
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake between the UART receive side (master) and the
// program loader (slave). A byte transfers when RxValid & RxReady at the edge.
interface program_loader_if;
   logic [7:0] RxData;
   logic       RxValid;
   logic       RxReady;

   modport master (
      output RxData,
      output RxValid,
      input  RxReady
   );

   modport slave (
      input  RxData,
      input  RxValid,
      output RxReady
   );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory stage: holds the program RAM, loads it from a framed,
// checksummed byte stream and keeps the CPU in reset until an image is valid.
// Frame: count hi, count lo, N x (word hi, word lo), checksum of data bytes.
module program_loader #(
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_WORDS  = 2048
) (
   input  logic                  Clock,
   input  logic                  Reset,
   program_loader_if.slave       rx,
   input  logic                  Reload,
   input  logic [ADDR_WIDTH-1:0] InsAddr,
   output logic [15:0]           Instruction,
   output logic                  CpuReset,
   output logic                  Loaded,
   output logic                  Error
);

   typedef enum logic [2:0] {
      S_CNT_HI,
      S_CNT_LO,
      S_W_HI,
      S_W_LO,
      S_CSUM,
      S_RUN,
      S_ERROR
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [15:0]             word_count;
   logic [ADDR_WIDTH-1:0]   ptr;
   logic [7:0]              sum;
   logic [7:0]              hi_byte;
   logic [15:0]             mem [2**ADDR_WIDTH];
   logic                    rx_ready;
   logic                    accept;
   logic [15:0]             count_in;
   logic [15:0]             ptr_inc;

   // Loader takes bytes in every loading state; never during the reset cycle.
   assign rx_ready    = !Reset && (state != S_RUN) && (state != S_ERROR);
   assign rx.RxReady  = rx_ready;
   // A byte arriving with Reload is handshaked but deliberately dropped.
   assign accept      = rx.RxValid && rx_ready && !Reload;
   assign count_in    = {word_count[15:8], rx.RxData};
   // Widened so the final write of a 2^ADDR_WIDTH-word image compares correctly.
   assign ptr_inc     = 16'(ptr) + 16'd1;

   // Next-state logic: the frame parser advances only on an accepted byte.
   always_comb begin
      state_next = state;
      if (accept) begin
         unique case (state)
            S_CNT_HI: state_next = S_CNT_LO;
            S_CNT_LO: state_next = (count_in == 16'd0 || 32'(count_in) > 32'(MAX_WORDS))
                                   ? S_ERROR : S_W_HI;
            S_W_HI:   state_next = S_W_LO;
            S_W_LO:   state_next = (ptr_inc == word_count) ? S_CSUM : S_W_HI;
            S_CSUM:   state_next = (sum == rx.RxData) ? S_RUN : S_ERROR;
            default:  state_next = state;
         endcase
      end
      if (Reload) state_next = S_CNT_HI;
   end

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) state <= S_CNT_HI;
      else       state <= state_next;
   end

   // Registered status outputs, updated on the same edge the state changes.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         CpuReset <= 1'b1;
         Loaded   <= 1'b0;
         Error    <= 1'b0;
      end else begin
         CpuReset <= (state_next != S_RUN);
         Loaded   <= (state_next == S_RUN);
         Error    <= (state_next == S_ERROR);
      end
   end

   // Frame datapath: word count, write pointer, running checksum, held hi byte.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         word_count <= '0;
         ptr        <= '0;
         sum        <= '0;
         hi_byte    <= '0;
      end else if (Reload) begin
         ptr <= '0;
         sum <= '0;
      end else if (accept) begin
         unique case (state)
            S_CNT_HI: word_count[15:8] <= rx.RxData;
            S_CNT_LO: word_count[7:0]  <= rx.RxData;
            S_W_HI: begin
               hi_byte <= rx.RxData;
               sum     <= sum + rx.RxData;
            end
            S_W_LO: begin
               sum <= sum + rx.RxData;
               ptr <= ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Program RAM write on the edge that accepts the lo byte; contents survive reset.
   always_ff @(posedge Clock) begin
      if (accept && state == S_W_LO) mem[ptr] <= {hi_byte, rx.RxData};
   end

   // Fetch port: anything outside a loaded image reads as a NOP.
   assign Instruction = (Loaded && 16'(InsAddr) < word_count) ? mem[InsAddr] : '0;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames against a frame-level reference model.
module tb_program_loader;
   localparam int AW   = 11;
   localparam int MAXW = 2048;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Reload;
   logic [AW-1:0] InsAddr;
   logic [15:0]   Instruction;
   logic          CpuReset;
   logic          Loaded;
   logic          Error;

   program_loader_if rx();

   program_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .rx          (rx.slave),
      .Reload      (Reload),
      .InsAddr     (InsAddr),
      .Instruction (Instruction),
      .CpuReset    (CpuReset),
      .Loaded      (Loaded),
      .Error       (Error)
   );

   always #5 Clock = ~Clock;

   int tests = 0;
   int fails = 0;

   // Reference model state: image as the stream delivered it, and outcome.
   logic [15:0] ref_mem [MAXW];
   int          ref_n      = 0;
   bit          ref_loaded = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer one byte after `gap` idle cycles; returns once the loader takes it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge Clock);
         rx.RxValid = 1'b0;
         rx.RxData  = 8'($urandom);
      end
      @(negedge Clock);
      rx.RxData  = b;
      rx.RxValid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (rx.RxReady) begin
            @(posedge Clock);
            #1;
            rx.RxValid = 1'b0;
            return;
         end
         @(negedge Clock);
      end
      rx.RxValid = 1'b0;
      check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_status(input string tag, input bit cpu_rst, input bit ld,
                               input bit err, input bit rdy);
      check({tag, "_cpureset"}, 32'(CpuReset),   32'(cpu_rst));
      check({tag, "_loaded"},   32'(Loaded),     32'(ld));
      check({tag, "_error"},    32'(Error),      32'(err));
      check({tag, "_rxready"},  32'(rx.RxReady), 32'(rdy));
   endtask

   task automatic check_fetch(input int addr);
      logic [15:0] exp;
      @(negedge Clock);
      InsAddr = AW'(addr);
      #1;
      exp = (ref_loaded && addr < ref_n) ? ref_mem[addr] : 16'h0000;
      check($sformatf("fetch_%0d", addr), 32'(Instruction), 32'(exp));
   endtask

   task automatic pulse_reload();
      @(negedge Clock);
      rx.RxValid = 1'b0;
      Reload     = 1'b1;
      @(posedge Clock);
      #1;
      Reload     = 1'b0;
      ref_loaded = 0;
      check_status("reload", 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   // Build a frame; corrupt != 0 makes the checksum wrong by that amount.
   function automatic void build_frame(input int n, input logic [15:0] words[$],
                                       input int corrupt, output logic [7:0] q[$]);
      logic [7:0] s = 8'h00;
      q = {};
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int i = 0; i < words.size(); i++) begin
         q.push_back(words[i][15:8]);
         q.push_back(words[i][7:0]);
         s = s + words[i][15:8] + words[i][7:0];
      end
      q.push_back(s + 8'(corrupt));
   endfunction

   // Send a frame and check the outcome predicted from the frame rules.
   task automatic send_frame(input logic [7:0] q[$], input int maxgap);
      int          n;
      int          last;
      bit          ok;
      logic [7:0]  s;
      n = {q[0], q[1]};
      if (n == 0 || n > MAXW) begin
         ok   = 0;
         last = 1;
      end else begin
         s = 8'h00;
         for (int i = 2; i < 2 + 2 * n; i++) s = s + q[i];
         ok   = (s == q[2 + 2 * n]);
         last = 2 + 2 * n;
      end
      for (int i = 0; i <= last; i++) begin
         if (i == last) begin
            @(negedge Clock);
            check("pre_last_cpureset", 32'(CpuReset), 32'd1);
         end
         if (i == 3) begin
            @(negedge Clock);
            InsAddr = '0;
            #1;
            check("midload_fetch_masked", 32'(Instruction), 32'd0);
         end
         send_byte(q[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
         if (i >= 3 && i <= 2 * n + 1 && (i % 2) == 1)
            ref_mem[(i - 3) / 2] = {q[i - 1], q[i]};
      end
      ref_n      = n;
      ref_loaded = ok;
      if (ok) check_status("frame_ok", 1'b0, 1'b1, 1'b0, 1'b0);
      else    check_status("frame_err", 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   logic [7:0]  fq[$];
   logic [15:0] wq[$];

   initial begin
      Reset      = 1'b1;
      Reload     = 1'b0;
      InsAddr    = '0;
      rx.RxData  = '0;
      rx.RxValid = 1'b0;

      // Reset state
      @(negedge Clock);
      #1;
      check("reset_rxready_comb", 32'(rx.RxReady), 32'd0);
      @(posedge Clock);
      #1;
      check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check_status("post_reset", 1'b1, 1'b0, 1'b0, 1'b1);
      check("post_reset_fetch", 32'(Instruction), 32'd0);

      // Frame 1
      wq = {16'h1801, 16'h2801, 16'h0800};
      build_frame(3, wq, 0, fq);
      check("frame1_csum_byte", 32'(fq[8]), 32'h4A);
      send_frame(fq, 0);
      for (int a = 0; a < 4; a++) check_fetch(a);
      check_fetch(2047);

      // Frame 1 with bad checksum
      pulse_reload();
      build_frame(3, wq, 1, fq);
      send_frame(fq, 0);
      for (int a = 0; a < 4; a++) check_fetch(a);

      // Count 0 and count 2049 both fail right after the count
      pulse_reload();
      fq = {8'h00, 8'h00};
      send_frame(fq, 0);
      // Bytes offered in ERROR are ignored
      @(negedge Clock);
      rx.RxValid = 1'b1;
      rx.RxData  = 8'h55;
      repeat (3) @(posedge Clock);
      #1;
      rx.RxValid = 1'b0;
      check_status("error_ignores", 1'b1, 1'b0, 1'b1, 1'b0);
      pulse_reload();
      fq = {8'h08, 8'h01};
      send_frame(fq, 0);
      check_fetch(0);

      // Frame 1 with RxValid toggled every other cycle
      pulse_reload();
      build_frame(3, wq, 0, fq);
      for (int i = 0; i < fq.size(); i++) send_byte(fq[i], 1);
      ref_n      = 3;
      ref_loaded = 1;
      check_status("toggled", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int a = 0; a < 4; a++) check_fetch(a);

      // Reload after 3 of 6 data bytes, then the full frame
      pulse_reload();
      for (int i = 0; i < 5; i++) send_byte(fq[i], 0);
      pulse_reload();
      send_frame(fq, 0);
      for (int a = 0; a < 4; a++) check_fetch(a);

      // Reset held 2 cycles while running
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      check("run_reset_rxready", 32'(rx.RxReady), 32'd0);
      repeat (2) begin
         @(posedge Clock);
         #1;
         check_status("run_reset", 1'b1, 1'b0, 1'b0, 1'b0);
      end
      @(negedge Clock);
      Reset      = 1'b0;
      ref_loaded = 0;
      #1;
      check_status("run_reset_rel", 1'b1, 1'b0, 1'b0, 1'b1);

      // Largest accepted image
      wq = {};
      for (int i = 0; i < MAXW; i++) wq.push_back(16'($urandom));
      build_frame(MAXW, wq, 0, fq);
      send_frame(fq, 0);
      check_fetch(0);
      check_fetch(1024);
      check_fetch(MAXW - 1);

      // Randomized frames, some aborted by Reload, some with bad checksum
      for (int it = 0; it < 20; it++) begin
         int n;
         pulse_reload();
         n  = int'($urandom_range(12, 1));
         wq = {};
         for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
         if ($urandom_range(3, 0) == 0) begin
            build_frame(n, wq, 0, fq);
            for (int i = 0; i < int'($urandom_range(2 * n + 1, 1)); i++)
               send_byte(fq[i], int'($urandom_range(2, 0)));
            pulse_reload();
         end
         build_frame(n, wq, ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 1)) : 0, fq);
         send_frame(fq, 2);
         for (int a = 0; a <= n; a++) check_fetch(a);
         check_fetch(int'($urandom_range(MAXW - 1, 13)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
